// File: rtl/rcn_slave_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rcn_slave_fifo
//  Brief    : Ring-bus slave that turns hit requests into fixed-latency backend
//             accesses and reinserts their responses through a 4-deep FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module rcn_slave_fifo #(
    parameter logic [23:0] ADDR_MASK = 24'hFF0000,
    parameter logic [23:0] ADDR_BASE = 24'h000000,
    parameter int          RD_DELAY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [68:0] rcn_in,
    output logic [68:0] rcn_out,
    output logic        cs,
    output logic        wr,
    output logic [3:0]  mask,
    output logic [23:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    localparam int          c_META_W  = 67;
    localparam logic [2:0]  c_CREDITS = 3'd4;

    // Slot fields
    logic        w_vld;
    logic        w_req;
    logic [23:0] w_addr;
    logic        w_hit;
    logic        w_acc;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic [c_META_W-1:0] w_push_entry;

    // Backend pipeline: valid bits plus the slot body (wr..data) per stage
    logic [RD_DELAY-1:0] r_pv;
    logic [c_META_W-1:0] r_pmeta [RD_DELAY];

    // Response FIFO
    logic [c_META_W-1:0] r_fifo [4];
    logic [1:0]          r_wptr;
    logic [1:0]          r_rptr;
    logic [2:0]          r_fcnt;
    logic [2:0]          r_outstanding;

    assign w_vld   = rcn_in[68];
    assign w_req   = rcn_in[67];
    assign w_addr  = {rcn_in[53:32], 2'b00};
    assign w_hit   = w_vld && w_req && ((w_addr & ADDR_MASK) == ADDR_BASE);
    assign w_acc   = w_hit && (r_outstanding < c_CREDITS);
    assign w_empty = !w_vld || w_acc;
    assign w_pop   = w_empty && (r_fcnt != 3'd0);
    assign w_push  = r_pv[RD_DELAY-1];

    // Writes echo their own data; reads capture the backend result
    assign w_push_entry = {r_pmeta[RD_DELAY-1][66:32],
                           r_pmeta[RD_DELAY-1][66] ? r_pmeta[RD_DELAY-1][31:0] : rdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv <= '0;
        end else begin
            r_pv[0] <= w_acc;
            for (int k = 1; k < RD_DELAY; k++) begin
                r_pv[k] <= r_pv[k-1];
            end
        end
        if (w_acc) begin
            r_pmeta[0] <= rcn_in[66:0];
        end
        for (int k = 1; k < RD_DELAY; k++) begin
            r_pmeta[k] <= r_pmeta[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= 2'd0;
            r_rptr <= 2'd0;
            r_fcnt <= 3'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_push_entry;
                r_wptr         <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 3'd1;
                2'b01:   r_fcnt <= r_fcnt - 3'd1;
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // Credits span both the backend pipeline and the FIFO, so a push can never overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= 3'd0;
        end else begin
            case ({w_acc, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 3'd1;
                2'b01:   r_outstanding <= r_outstanding - 3'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcn_out <= 69'd0;
        end else if (w_pop) begin
            rcn_out <= {1'b1, 1'b0, r_fifo[r_rptr]};
        end else if (w_acc) begin
            rcn_out <= 69'd0;
        end else begin
            rcn_out <= rcn_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs    <= 1'b0;
            wr    <= 1'b0;
            mask  <= 4'd0;
            addr  <= 24'd0;
            wdata <= 32'd0;
        end else begin
            cs <= w_acc;
            if (w_acc) begin
                wr    <= rcn_in[66];
                mask  <= rcn_in[57:54];
                addr  <= w_addr;
                wdata <= rcn_in[31:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rcn_slave_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rcn_slave_fifo
//  Brief    : Directed bench driving three rcn_slave_fifo instances
//             (RD_DELAY 1, 2, 4) against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rcn_slave_fifo;

    logic        clk;
    logic        rst;
    logic [68:0] rcn_in;
    logic [31:0] rdata;

    logic [2:0][68:0] w_out;
    logic [2:0]       w_cs;
    logic [2:0]       w_wr;
    logic [2:0][3:0]  w_mask;
    logic [2:0][23:0] w_addr;
    logic [2:0][31:0] w_wdata;

    int checks = 0;
    int errors = 0;
    int nstep  = 0;
    bit rd_hold = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [68:0] mk(input logic w, input logic [5:0] id, input logic [1:0] sq,
                                       input logic [3:0] m, input logic [23:0] a, input logic [31:0] d);
        return {1'b1, 1'b1, w, id, sq, m, a[23:2], d};
    endfunction

    task automatic step(input logic [68:0] slot);
        rcn_in = slot;
        if (!rd_hold) rdata = 32'hC0DE_0000 + nstep;
        nstep++;
        @(posedge clk);
        #1;
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int D = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;

        rcn_slave_fifo #(.RD_DELAY(D)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .rcn_in  (rcn_in),
            .rcn_out (w_out[gi]),
            .cs      (w_cs[gi]),
            .wr      (w_wr[gi]),
            .mask    (w_mask[gi]),
            .addr    (w_addr[gi]),
            .wdata   (w_wdata[gi]),
            .rdata   (rdata)
        );

        // Reference: requests in flight carry the cycle they complete on
        logic [68:0] m_fifo [$];
        logic [68:0] m_pipe [$];
        int          m_due  [$];
        int          m_cyc;
        bit          m_live;
        logic [68:0] e_out;
        logic        e_cs;
        logic [60:0] e_be;

        initial begin : model
            logic [68:0] s;
            logic [68:0] r;
            logic [23:0] a;
            bit          hit;
            bit          acc;
            m_cyc  = 0;
            m_live = 0;
            e_out  = '0;
            e_cs   = 1'b0;
            e_be   = '0;
            forever begin
                @(posedge clk);
                if (rst) begin
                    m_fifo.delete();
                    m_pipe.delete();
                    m_due.delete();
                    e_out  = '0;
                    e_cs   = 1'b0;
                    e_be   = '0;
                    m_live = 1;
                end else begin
                    s   = rcn_in;
                    a   = {s[53:32], 2'b00};
                    hit = s[68] && s[67] && (a[23:16] == 8'h00);
                    acc = hit && ((m_pipe.size() + m_fifo.size()) < 4);
                    e_out = acc ? 69'd0 : s;
                    if ((!s[68] || acc) && m_fifo.size() > 0) e_out = m_fifo.pop_front();
                    if (m_pipe.size() > 0 && m_due[0] == m_cyc) begin
                        r = m_pipe.pop_front();
                        void'(m_due.pop_front());
                        if (!r[66]) r[31:0] = rdata;
                        m_fifo.push_back(r);
                    end
                    e_cs = acc;
                    if (acc) begin
                        m_pipe.push_back({2'b10, s[66:0]});
                        m_due.push_back(m_cyc + D);
                        e_be = {s[66], s[57:54], a, s[31:0]};
                    end
                end
                m_cyc++;
            end
        end

        initial begin : compare
            forever begin
                @(negedge clk);
                if (m_live) begin
                    chk($sformatf("d%0d rcn_out", D), w_out[gi], e_out);
                    chk($sformatf("d%0d cs", D), {68'd0, w_cs[gi]}, {68'd0, e_cs});
                    chk($sformatf("d%0d backend", D),
                        {8'd0, w_wr[gi], w_mask[gi], w_addr[gi], w_wdata[gi]}, {8'd0, e_be});
                end
            end
        end
    end

    initial begin : stim
        logic [68:0] s;
        logic [68:0] r;
        rst    = 1'b1;
        rcn_in = '0;
        rdata  = '0;
        repeat (3) step('0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset out %0d", i), w_out[i], 69'd0);
            chk($sformatf("reset cs %0d", i), {68'd0, w_cs[i]}, 69'd0);
        end
        rst = 1'b0;

        // Miss under the default window passes through untouched
        s = mk(1'b0, 6'd1, 2'd0, 4'hF, 24'h010000, 32'h11223344);
        step(s);
        chk("miss out", w_out[0], s);
        chk("miss cs", {68'd0, w_cs[0]}, 69'd0);
        step('0);

        // Read of 0x10 returning DEADBEEF
        rd_hold = 1;
        rdata   = 32'hDEADBEEF;
        step(mk(1'b0, 6'd5, 2'd2, 4'hF, 24'h000010, 32'h0));
        chk("rd cs", {68'd0, w_cs[0]}, {68'd0, 1'b1});
        chk("rd addr", {45'd0, w_addr[0]}, {45'd0, 24'h000010});
        chk("rd consumed", w_out[0], 69'd0);
        step('0);
        step('0);
        chk("rd rsp", w_out[0], {1'b1, 1'b0, 1'b0, 6'd5, 2'd2, 4'hF, 22'h4, 32'hDEADBEEF});
        repeat (4) step('0);
        rd_hold = 0;

        // Write echoes its data in the response
        step(mk(1'b1, 6'd3, 2'd1, 4'h3, 24'h000004, 32'h12345678));
        chk("wr cs", {68'd0, w_cs[0]}, {68'd0, 1'b1});
        chk("wr wr", {68'd0, w_wr[0]}, {68'd0, 1'b1});
        chk("wr mask", {65'd0, w_mask[0]}, {65'd0, 4'h3});
        chk("wr wdata", {37'd0, w_wdata[0]}, {37'd0, 32'h12345678});
        step('0);
        step('0);
        chk("wr rsp", w_out[0], {1'b1, 1'b0, 1'b1, 6'd3, 2'd1, 4'h3, 22'h1, 32'h12345678});
        repeat (4) step('0);

        // Five hits back to back: the deep instance fills its credits and recirculates the fifth
        for (int k = 0; k < 5; k++) begin
            s = mk(1'b0, 6'(10 + k), 2'(k), 4'hF, 24'(32'h20 + 4 * k), 32'h0);
            step(s);
        end
        chk("full pass", w_out[2], s);
        for (int k = 0; k < 4; k++) begin
            step('0);
            r = w_out[2];
            chk($sformatf("drain %0d", k), {60'd0, r[68:60]}, {60'd0, 1'b1, 1'b0, 1'b0, 6'(10 + k)});
        end
        step('0);
        chk("drained", w_out[2], 69'd0);
        repeat (3) step('0);

        // Continuous hits: the RD_DELAY=2 instance settles at three outstanding
        for (int k = 1; k <= 8; k++) begin
            step(mk(1'b0, 6'(19 + k), 2'd0, 4'hF, 24'(32'h100 + 4 * k), 32'h0));
            r = w_out[1];
            if (k <= 3) chk($sformatf("stream %0d", k), r, 69'd0);
            else chk($sformatf("stream %0d", k), {60'd0, r[68:60]},
                     {60'd0, 1'b1, 1'b0, 1'b0, 6'(16 + k)});
        end
        repeat (12) step('0);

        // Reset one cycle after an accept discards the transaction
        step(mk(1'b0, 6'd30, 2'd0, 4'hF, 24'h000040, 32'h0));
        rst = 1'b1;
        step('0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst out %0d", i), w_out[i], 69'd0);
            chk($sformatf("rst cs %0d", i), {68'd0, w_cs[i]}, 69'd0);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step('0);
            for (int i = 0; i < 3; i++) chk($sformatf("post rst %0d.%0d", i, k), w_out[i], 69'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rcn_slave_fifo.md
RCN_SLAVE_FIFO -- requirements
Module: rcn_slave_fifo

Interface
REQ-001 SHALL have parameter ADDR_MASK, default 24'hFF0000, the address bits compared for a hit.
REQ-002 SHALL have parameter ADDR_BASE, default 24'h000000, the hit value of (addr & ADDR_MASK).
REQ-003 SHALL have parameter RD_DELAY, default 1, legal range 1..4: cycles from cs to valid rdata.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port rcn_in, input, 69, the upstream ring slot.
REQ-007 SHALL have port rcn_out, output, 69, the registered downstream ring slot.
REQ-008 SHALL have port cs, output, 1, the registered backend access strobe.
REQ-009 SHALL have port wr, output, 1, the backend write qualifier.
REQ-010 SHALL have port mask, output, 4, the backend byte enables.
REQ-011 SHALL have port addr, output, 24, the backend byte address with bits [1:0]=0.
REQ-012 SHALL have port wdata, output, 32, the backend write data.
REQ-013 SHALL have port rdata, input, 32, the backend read data, sampled exactly RD_DELAY cycles after cs.

Function
REQ-014 SHALL decode each slot as [68] vld, [67] req, [66] wr, [65:60] id, [59:58] seq, [57:54] mask, [53:32] addr[23:2], [31:0] data.
REQ-015 SHALL define hit = vld & req & (({addr[23:2],2'b00} & ADDR_MASK) == ADDR_BASE).
REQ-016 SHALL keep a 3-bit credit counter `outstanding` (0..4), covering accepted requests in the backend pipeline plus FIFO entries.
REQ-017 SHALL accept a hit only when outstanding < 4; a hit with outstanding == 4 SHALL pass to rcn_out unchanged, so the ring recirculates it.
REQ-018 SHALL, on accept, assert cs for one cycle in the following cycle, with wr/mask/addr/wdata taken from the slot.
REQ-019 SHALL treat the accepted slot as empty for the insertion decision in that same cycle.
REQ-020 SHALL carry id, seq, wr, mask and addr alongside the access for RD_DELAY cycles, then push one entry into a 4-deep response FIFO.
REQ-021 SHALL set the pushed entry's data to rdata for reads, and to the original wdata for writes.
REQ-022 SHALL insert the FIFO head into the slot when the FIFO is non-empty and the slot is empty (vld=0, or consumed per REQ-019), then pop the head.
REQ-023 SHALL build an inserted response as vld=1, req=0, with wr, id, seq, mask, addr and data taken from the entry.
REQ-024 SHALL pass every other slot unchanged to rcn_out with one cycle of latency; this covers non-hits, responses, and a vld=0 slot with an empty FIFO.
REQ-025 SHALL leave outstanding unchanged on a simultaneous accept and pop, increment it on accept alone, and decrement it on pop alone.
REQ-026 SHALL never overflow or underflow the FIFO; because of REQ-017, a push into a full FIFO SHALL be impossible.
REQ-027 SHALL deliver responses in acceptance order; the backend pipeline is in-order and fixed-latency.
REQ-028 SHALL hold wr/mask/addr/wdata at their last values while cs=0.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear rcn_out to 69'd0, cs to 0, outstanding to 0, the FIFO pointers to empty, and all pipeline-valid bits.
REQ-030 SHALL drop any transaction that is in flight when rst asserts, and emit no response for it.
REQ-031 SHALL clear wr, mask, addr and wdata to 0 on reset.

Verification
REQ-032 SHALL pass this scenario: with RD_DELAY=1, a read slot id=5, seq=2, addr=24'h000010, mask=4'hF, with rdata=32'hDEADBEEF, produces cs one cycle later with addr=24'h000010, and the next empty slot carries a response with vld=1, req=0, id=5, seq=2, data=32'hDEADBEEF.
REQ-033 SHALL pass this scenario: a write with addr=24'h000004, mask=4'h3, data=32'h12345678 produces cs=1, wr=1, mask=4'h3, wdata=32'h12345678, and a response with wr=1 and data=32'h12345678.
REQ-034 SHALL pass this scenario: a request with addr=24'h010000 (a miss under the defaults) appears on rcn_out one cycle later bit-identical to the input, and cs stays 0.
REQ-035 SHALL pass this scenario: 5 back-to-back hit requests with no empty slots accept exactly 4 (outstanding=4) and pass the 5th unchanged; after empty slots are supplied, 4 responses drain in order and outstanding returns to 0.
REQ-036 SHALL pass this scenario: a continuous stream of hit requests with outstanding=3 accepts each one and inserts a response into its freed slot in the same cycle, holding outstanding at 3.
REQ-037 SHALL pass this scenario: asserting rst one cycle after an accept gives rcn_out=0 and cs=0, and no response ever emerges after release.
